// File: rtl/restoring_divider_seq.sv
// restoring_divider_seq: unsigned restoring divider, one quotient bit per clock with start/done handshake
module restoring_divider_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  // The partial remainder always ends an iteration below the divisor, so its
  // top bit is zero and only WIDTH bits are kept; the shifted trial value is WIDTH+1 bits.
  logic [WIDTH-1:0] a, a_nx, q, q_nx, m;
  logic [WIDTH:0]   a_sh, t;
  logic [CW-1:0]    count;
  logic             zero, last;
  // One restoring iteration: shift {A,Q} left, trial-subtract M, keep or restore
  always_comb begin
    zero = divisor == '0;
    last = count == CW'(1);
    a_sh = {a, q[WIDTH-1]};
    t    = a_sh - {1'b0, m};
    a_nx = t[WIDTH] ? a_sh[WIDTH-1:0] : t[WIDTH-1:0];
    q_nx = {q[WIDTH-2:0], ~t[WIDTH]};
  end
  // Next-state: RUN ignores start; IDLE/DONE accept start, zero divisor skips to DONE
  always_comb begin
    state_nx = state;
    if (state == RUN) state_nx = last ? DONE : RUN;
    else if (start) state_nx = zero ? DONE : RUN;
    else if (state == DONE) state_nx = IDLE;
  end
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // Datapath: load operands, iterate, and publish results on the final iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a           <= '0;
      q           <= '0;
      m           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (state == RUN) begin
      a     <= a_nx;
      q     <= q_nx;
      count <= count - CW'(1);
      if (last) begin
        quotient    <= q_nx;
        remainder   <= a_nx;
        div_by_zero <= 1'b0;
      end
    end else if (start) begin
      if (zero) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        a     <= '0;
        q     <= dividend;
        m     <= divisor;
        count <= CW'(WIDTH);
      end
    end
  end
  assign busy = state == RUN;
  assign done = state == DONE;
endmodule

// File: tb/tb_restoring_divider_seq.sv
// tb_restoring_divider_seq: directed and random checks of the divider against an arithmetic model
module tb_restoring_divider_seq;
  localparam int W = 8;
  logic clk = 0, rst_n = 0, start = 0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  int checks = 0, failures = 0;

  restoring_divider_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining busy cycles plus results from plain / and %
  int m_cnt = 0;
  bit m_done = 0;
  logic [W-1:0] m_q = 0, m_r = 0, p_q, p_r, p_dd, p_dv, l_dd, l_dv;
  bit m_dbz = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_done = 0; m_q = 0; m_r = 0; m_dbz = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      m_done = m_cnt == 0;
      if (m_done) begin m_q = p_q; m_r = p_r; m_dbz = 0; l_dd = p_dd; l_dv = p_dv; end
    end else if (start) begin
      if (divisor == 0) begin
        m_done = 1; m_q = '1; m_r = dividend; m_dbz = 1;
      end else begin
        m_done = 0; m_cnt = W;
        p_q = dividend / divisor; p_r = dividend % divisor; p_dd = dividend; p_dv = divisor;
      end
    end else m_done = 0;
  end

  // Every-cycle comparison against the model, plus the algebraic invariant at done
  always @(negedge clk) if (rst_n) begin
    chk("busy", busy, m_cnt > 0);
    chk("done", done, m_done);
    chk("quotient", quotient, m_q);
    chk("remainder", remainder, m_r);
    chk("div_by_zero", div_by_zero, m_dbz);
    if (done && !div_by_zero) begin
      chk("invariant_eq", 32'(quotient) * 32'(l_dv) + 32'(remainder), 32'(l_dd));
      chk("invariant_lt", remainder < l_dv, 1);
    end
  end

  task automatic do_start(input logic [W-1:0] dd, input logic [W-1:0] dv);
    @(negedge clk);
    dividend = dd; divisor = dv; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int max);
    int i;
    for (i = 0; i < max && !done; i++) @(negedge clk);
    if (!done) begin
      failures++;
      $display("FAIL wait_done: timeout after %0d cycles", max);
    end
  endtask

  task automatic div_lit(input logic [W-1:0] dd, input logic [W-1:0] dv,
                         input logic [W-1:0] eq, input logic [W-1:0] er);
    do_start(dd, dv);
    wait_done(W + 4);
    chk("lit_q", quotient, eq);
    chk("lit_r", remainder, er);
    @(negedge clk);
  endtask

  initial begin
    int n, pulses;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1;
    // 1: 100/7 with busy-length check
    do_start(100, 7);
    n = 0;
    while (busy && n < 20) begin n++; @(negedge clk); end
    chk("busy_len", n, 8);
    chk("t1_done", done, 1);
    chk("t1_q", quotient, 14);
    chk("t1_r", remainder, 2);
    chk("t1_dbz", div_by_zero, 0);
    @(negedge clk);
    // 2: boundary operands
    div_lit(255, 1, 255, 0);
    div_lit(5, 9, 0, 5);
    div_lit(255, 255, 1, 0);
    div_lit(0, 3, 0, 0);
    // 3: divide by zero finishes in the cycle after the start edge
    do_start(37, 0);
    chk("dz_done", done, 1);
    chk("dz_busy", busy, 0);
    chk("dz_q", quotient, 8'hFF);
    chk("dz_r", remainder, 37);
    chk("dz_flag", div_by_zero, 1);
    @(negedge clk);
    // 4: start during RUN is ignored
    do_start(100, 7);
    @(negedge clk);
    dividend = 200; divisor = 3; start = 1;
    @(negedge clk);
    start = 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        pulses++;
        chk("t4_q", quotient, 14);
        chk("t4_r", remainder, 2);
      end
      @(negedge clk);
    end
    chk("t4_pulses", pulses, 1);
    // 5: asynchronous reset mid-RUN
    do_start(100, 7);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_q", quotient, 0);
    chk("ar_r", remainder, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (12) @(negedge clk);
    div_lit(9, 2, 4, 1);
    // 6: start held through DONE gives back-to-back runs
    @(negedge clk);
    dividend = 100; divisor = 7; start = 1;
    @(negedge clk);
    wait_done(W + 4);
    chk("b2b_q1", quotient, 14);
    chk("b2b_r1", remainder, 2);
    dividend = 250; divisor = 16;
    @(negedge clk);
    chk("b2b_busy", busy, 1);
    start = 0;
    wait_done(W + 4);
    chk("b2b_q2", quotient, 15);
    chk("b2b_r2", remainder, 10);
    @(negedge clk);
    // Random operands, some with zero divisor
    for (int i = 0; i < 300; i++) begin
      do_start(W'($urandom), ($urandom_range(0, 15) == 0) ? W'(0) : W'($urandom));
      wait_done(W + 4);
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
